// File: rtl/rom_loader.sv
// Framed ROM image loader: SYNC, 16-bit word length, little-endian data words.
// Optional ROM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module rom_loader #(
    parameter int          AW          = 12,
    parameter int          DW          = 32,
    parameter int          MAX_WORDS   = 4096,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_i,
    output logic          byte_ready_o,
    output logic          rom_w_en_o,
    output logic [AW-1:0] rom_w_addr_o,
    output logic [DW-1:0] rom_w_data_o,
    output logic          cpu_hold_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   words_o
);
    typedef enum logic [2:0] {
        IDLE, LEN0, LEN1, DATA, DONE, ERR
`ifdef ROM_LOADER_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

`ifdef ROM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    localparam logic [16:0] MAXW     = 17'(MAX_WORDS);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t        state_q, state_d;
    logic          ready_q;
    logic [15:0]   len_q, len_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [23:0]   buf_q, buf_d;
    logic [AW:0]   words_q, words_d, w_next;
    logic          wen_q, wen_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          done_q, done_d, err_q, err_d, hold_q, hold_d;
    logic          accept, active, tmo_fire;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            len_q   <= '0;
            bcnt_q  <= '0;
            buf_q   <= '0;
            words_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            buf_q   <= buf_d;
            words_q <= words_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        words_d = words_q;
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        done_d  = done_q | (state_q == DONE);
        err_d   = err_q | (state_q == ERR);
        hold_d  = (state_q != IDLE) && (state_q != DONE);
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        w_next  = words_q + 1'b1;
        accept  = byte_valid_i & ready_q;
        active  = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
        // A byte landing on the expiry cycle wins over the timeout.
        tmo_fire = (TIMEOUT_CYC != 0) && active && !accept && (tmo_q == TMO_LAST);

        if (!active || accept)
            tmo_d = '0;
        else if (TIMEOUT_CYC != 0)
            tmo_d = tmo_q + 32'd1;

        case (state_q)
            LEN0: if (accept) begin
                len_d[7:0] = byte_i;
                state_d    = LEN1;
            end
            LEN1: if (accept) begin
                len_d[15:8] = byte_i;
                if ({byte_i, len_q[7:0]} == 16'd0)
                    state_d = FIN;
                else if ({1'b0, byte_i, len_q[7:0]} > MAXW)
                    state_d = ERR;
                else
                    state_d = DATA;
            end
            DATA: if (accept) begin
                bcnt_d = bcnt_q + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                csum_d = csum_q ^ byte_i;
`endif
                case (bcnt_q)
                    2'd0: buf_d[7:0]   = byte_i;
                    2'd1: buf_d[15:8]  = byte_i;
                    2'd2: buf_d[23:16] = byte_i;
                    default: begin
                        wen_d   = 1'b1;
                        waddr_d = words_q[AW-1:0];
                        wdata_d = DW'({byte_i, buf_q});
                        words_d = w_next;
                        if (17'(w_next) == {1'b0, len_q})
                            state_d = FIN;
                    end
                endcase
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            CSUM: if (accept)
                state_d = (byte_i == csum_q) ? DONE : ERR;
`endif
            default: if (accept && byte_i == SYNC_BYTE) begin
                state_d = LEN0;
                done_d  = 1'b0;
                err_d   = 1'b0;
                words_d = '0;
                bcnt_d  = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                csum_d  = '0;
`endif
            end
        endcase

        if (tmo_fire)
            state_d = ERR;
    end

    assign byte_ready_o = ready_q;
    assign rom_w_en_o   = wen_q;
    assign rom_w_addr_o = waddr_q;
    assign rom_w_data_o = wdata_q;
    assign cpu_hold_o   = hold_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign words_o      = words_q;
endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: vector table of frames plus timeout, reset and checksum sequences.
module tb_rom_loader;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_in = '0;
    logic          byte_ready, rom_w_en, cpu_hold, done, err;
    logic [AW-1:0] rom_w_addr;
    logic [DW-1:0] rom_w_data;
    logic [AW:0]   words;

    int errors = 0;
    int checks = 0;

    rom_loader #(.AW(AW), .DW(DW), .MAX_WORDS(4096), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .byte_valid_i(byte_valid), .byte_i(byte_in),
        .byte_ready_o(byte_ready), .rom_w_en_o(rom_w_en), .rom_w_addr_o(rom_w_addr),
        .rom_w_data_o(rom_w_data), .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err),
        .words_o(words)
    );

    always #5 clk = ~clk;

    // Write-port monitor: logs each strobe and flags strobes wider than one cycle.
    int          wcnt = 0;
    int          wr_addr [64];
    logic [31:0] wr_data [64];
    logic        prev_en = 1'b0;
    int          long_pulses = 0;
    always @(negedge clk) begin
        if (rom_w_en) begin
            if (wcnt < 64) begin
                wr_addr[wcnt] = int'(rom_w_addr);
                wr_data[wcnt] = rom_w_data;
            end
            wcnt = wcnt + 1;
            if (prev_en) long_pulses = long_pulses + 1;
        end
        prev_en = rom_w_en;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [95:0] b;       // bytes left-aligned, first byte in [95:88]
        int          n;
        int          pre;     // leading bytes that must not raise cpu_hold or write
        int          dstart;  // first data byte for checksum, -1 = no checksum byte
        int          nw;
        logic [31:0] d0, d1;
        int          done, err, hold, words;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        logic [7:0] cs;
        logic [7:0] bb;

        vecs[0] = '{"basic", 96'hA5_02_00_11_22_33_44_55_66_77_88_00, 11, 0, 3, 2,
                    32'h44332211, 32'h88776655, 1, 0, 0, 2};
        vecs[1] = '{"garbage", 96'h00_FF_5A_A5_01_00_DE_AD_BE_EF_00_00, 10, 3, 6, 1,
                    32'hEFBEADDE, 32'h0, 1, 0, 0, 1};
        vecs[2] = '{"oversize", 96'hA5_01_10_00_00_00_00_00_00_00_00_00, 3, 0, -1, 0,
                    32'h0, 32'h0, 0, 1, 1, 0};
        vecs[3] = '{"recover", 96'hA5_01_00_A5_A5_A5_A5_00_00_00_00_00, 7, 0, 3, 1,
                    32'hA5A5A5A5, 32'h0, 1, 0, 0, 1};
        vecs[4] = '{"zerolen", 96'hA5_00_00_00_00_00_00_00_00_00_00_00, 3, 0, 3, 0,
                    32'h0, 32'h0, 1, 0, 0, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(byte_ready), 64'd0);
        chk("rst_wen",   64'(rom_w_en),   64'd0);
        chk("rst_addr",  64'(rom_w_addr), 64'd0);
        chk("rst_data",  64'(rom_w_data), 64'd0);
        chk("rst_hold",  64'(cpu_hold),   64'd0);
        chk("rst_done",  64'(done),       64'd0);
        chk("rst_err",   64'(err),        64'd0);
        chk("rst_words", 64'(words),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 64'(byte_ready), 64'd1);

        for (int v = 0; v < 5; v++) begin
            base = wcnt;
            cs = '0;
            for (int i = 0; i < vecs[v].n; i++) begin
                bb = vecs[v].b[95 - 8*i -: 8];
                if (vecs[v].dstart >= 0 && i >= vecs[v].dstart) cs = cs ^ bb;
                send_byte(bb);
                if (i < vecs[v].pre) begin
                    chk({vecs[v].name, "_pre_hold"}, 64'(cpu_hold), 64'd0);
                    chk({vecs[v].name, "_pre_wr"}, 64'(wcnt - base), 64'd0);
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            if (vecs[v].dstart >= 0) send_byte(cs);
`endif
            repeat (3) @(posedge clk);
            #1;
            chk({vecs[v].name, "_nwrites"}, 64'(wcnt - base), 64'(vecs[v].nw));
            if (vecs[v].nw > 0) begin
                chk({vecs[v].name, "_a0"}, 64'(wr_addr[base]), 64'd0);
                chk({vecs[v].name, "_d0"}, 64'(wr_data[base]), 64'(vecs[v].d0));
            end
            if (vecs[v].nw > 1) begin
                chk({vecs[v].name, "_a1"}, 64'(wr_addr[base+1]), 64'd1);
                chk({vecs[v].name, "_d1"}, 64'(wr_data[base+1]), 64'(vecs[v].d1));
            end
            chk({vecs[v].name, "_done"},  64'(done),     64'(vecs[v].done));
            chk({vecs[v].name, "_err"},   64'(err),      64'(vecs[v].err));
            chk({vecs[v].name, "_hold"},  64'(cpu_hold), 64'(vecs[v].hold));
            chk({vecs[v].name, "_words"}, 64'(words),    64'(vecs[v].words));
            chk({vecs[v].name, "_ready"}, 64'(byte_ready), 64'd1);
        end

        // Timeout: silence after one data byte
        base = wcnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_err_early", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("tmo_err",    64'(err),         64'd1);
        chk("tmo_hold",   64'(cpu_hold),    64'd1);
        chk("tmo_nowr",   64'(wcnt - base), 64'd0);

        // Timeout suppressed by a byte on the expiry cycle
        base = wcnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        repeat (15) @(posedge clk);
        send_byte(8'hBB);
        repeat (2) @(posedge clk);
        #1;
        chk("tmo_sup_err", 64'(err), 64'd0);
        send_byte(8'hCC); send_byte(8'hDD);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("tmo_sup_done", 64'(done), 64'd1);
        chk("tmo_sup_err2", 64'(err),  64'd0);
        chk("tmo_sup_nwr",  64'(wcnt - base), 64'd1);
        chk("tmo_sup_data", 64'(wr_data[base]), 64'hDDCCBBAA);

        // Reset in the middle of a data word
        base = wcnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        rst = 1'b1;
        #1;
        chk("mrst_ready", 64'(byte_ready), 64'd0);
        chk("mrst_hold",  64'(cpu_hold),   64'd0);
        chk("mrst_done",  64'(done),       64'd0);
        chk("mrst_words", 64'(words),      64'd0);
        chk("mrst_addr",  64'(rom_w_addr), 64'd0);
        chk("mrst_data",  64'(rom_w_data), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(8'h04);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("mrst_nwr",   64'(wcnt - base),     64'd1);
        chk("mrst_a0",    64'(wr_addr[base]),   64'd0);
        chk("mrst_d0",    64'(wr_data[base]),   64'h04030201);
        chk("mrst_done2", 64'(done),            64'd1);

`ifdef ROM_LOADER_CHECKSUM_EN
        base = wcnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08); send_byte(8'h0F);
        repeat (3) @(posedge clk);
        #1;
        chk("cs_good_done", 64'(done), 64'd1);
        chk("cs_good_err",  64'(err),  64'd0);
        base = wcnt;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08); send_byte(8'h0E);
        repeat (3) @(posedge clk);
        #1;
        chk("cs_bad_err",  64'(err),  64'd1);
        chk("cs_bad_done", 64'(done), 64'd0);
        chk("cs_bad_nwr",  64'(wcnt - base), 64'd1);
        chk("cs_bad_d0",   64'(wr_data[base]), 64'h08040201);
`endif

        chk("strobe_width", 64'(long_pulses), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
